led_scan_ctrl: RTL and testbench
================================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter N_LEDS, default 6: number of LEDs driven; legal range 2..32.
REQ-002 Parameter CLK_HZ, default 27_000_000: sys_clk frequency in Hz.
REQ-003 Parameter STEP_MS, default 500: base step period in ms at speed 0.
REQ-004 Parameter DEB_MS, default 20: button debounce stability time in ms.
REQ-005 Parameter LED_ACTIVE_LOW, default 1: when 1, a lit LED is driven 0.
REQ-006 sys_clk  input  1  single clock for all logic.
REQ-007 sys_rst  input  1  reset, asynchronous and active-high.
REQ-008 btn_mode  input  1  raw mode button, active-low, asynchronous to sys_clk.
REQ-009 btn_speed  input  1  raw speed button, active-low, asynchronous to sys_clk.
REQ-010 led  output  N_LEDS  registered LED drive, polarity per LED_ACTIVE_LOW; led[0] is the rightmost LED.
REQ-011 mode  output  2  current pattern mode.
REQ-012 step  output  1  one-cycle pulse on every cycle the pattern advances.

Function
REQ-013 STEP_CYC = (CLK_HZ/1000)*STEP_MS and DEB_CYC = (CLK_HZ/1000)*DEB_MS shall be elaboration-time constants; counter widths shall be sized with $clog2 for these values.
REQ-014 A 2-bit speed register shall give period P = STEP_CYC >> speed, so speeds 0..3 step at 1x, 2x, 4x and 8x.
REQ-015 The prescaler shall count 0..P-1; at P-1 it shall return to 0 and assert step for exactly that cycle.
REQ-016 Each button shall pass through a 2-FF synchroniser and a debouncer that updates its debounced level only after the synchronised input has held a new value for DEB_CYC consecutive cycles.
REQ-017 A press event shall be a one-cycle pulse on a debounced 1->0 transition; releases shall produce no event.
REQ-018 The state shall be pos (0..N_LEDS-1) and dir (0 = toward MSB, 1 = toward LSB).
REQ-019 Mode 0 BOUNCE shall light bit pos only; on step, with dir=0, pos shall increment, and at pos=N_LEDS-1 it shall instead set dir=1 and pos=N_LEDS-2; with dir=1, pos shall decrement, and at pos=0 it shall instead set dir=0 and pos=1. No end LED is held for two steps.
REQ-020 Mode 1 ROT_L shall light bit pos only; on step, pos shall advance to (pos+1) mod N_LEDS.
REQ-021 Mode 2 ROT_R shall light bit pos only; on step, pos shall decrement, and from 0 shall wrap to N_LEDS-1.
REQ-022 Mode 3 FILL shall light bits 0..pos; on step, pos shall increment, and from N_LEDS-1 shall wrap to 0.
REQ-023 A mode press shall, in the following cycle, set mode to (mode+1) mod 4 (3 wraps to 0), set pos=0 and dir=0, and clear the prescaler.
REQ-024 A speed press shall set speed to (speed+1) mod 4 and clear the prescaler; pos, dir and mode shall be unchanged.
REQ-025 If a press and a prescaler terminal count fall in the same cycle, the press shall take effect, the pattern shall not advance, and step shall stay 0.
REQ-026 Simultaneous mode and speed presses shall both take effect in the same cycle.
REQ-027 led shall be registered and equal the pattern for the current mode and pos, XORed with {N_LEDS{LED_ACTIVE_LOW}}; it shall update in the same cycle pos or mode updates.

Reset
REQ-028 While sys_rst=1: mode=0, speed=0, pos=0, dir=0, prescaler=0, step=0, debouncers at released level (1), and led showing only bit 0 lit (6'b111110 at defaults).
REQ-029 Reset asserted mid-step or mid-debounce shall discard all partial counts; after release the first step shall occur exactly P cycles later.

Verification
All scenarios use CLK_HZ=1000, STEP_MS=4, DEB_MS=2, N_LEDS=6, LED_ACTIVE_LOW=1, giving STEP_CYC=4 and DEB_CYC=2.
REQ-030 Reset, then 48 cycles with no buttons -> step every 4th cycle; led sequence 111110,111101,111011,110111,101111,011111,101111,...,111110,111101 (BOUNCE, no repeated end LED).
REQ-031 One mode press held 10 cycles -> exactly one event; mode=1, pos=0; led 111110 then 111101...011111, then 111110 (ROT_L wrap).
REQ-032 Two further mode presses -> mode=3; successive led values 111110,111100,111000,110000,100000,000000, then 111110 (FILL wrap); a fourth press -> mode=0.
REQ-033 Speed press three times -> P=4,2,1,0 is illegal, so the bench shall use STEP_MS=8 (STEP_CYC=8) for this case; expect step spacing of 8, 4, 2 and 1 cycles, and a fourth press returns spacing to 8.
REQ-034 1-cycle glitches on btn_mode -> no event; a mode press landing on terminal count -> mode increments, step stays 0, and the next step follows P cycles later.
REQ-035 sys_rst pulsed asynchronously between clock edges in mode 2 at speed 2 -> outputs immediately take the REQ-028 values; the first step follows 4 cycles after release.

Source files
------------

// File: rtl/led_scan_ctrl.sv
// LED scanner: four moving-light patterns stepped by a prescaler,
// with debounced mode and speed buttons.
module led_scan_ctrl #(
    parameter int N_LEDS         = 6,
    parameter int CLK_HZ         = 27_000_000,
    parameter int STEP_MS        = 500,
    parameter int DEB_MS         = 20,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              btn_mode,
    input  logic              btn_speed,
    output logic [N_LEDS-1:0] led,
    output logic [1:0]        mode,
    output logic              step
);

    localparam int STEP_CYC = (CLK_HZ / 1000) * STEP_MS;
    localparam int DEB_CYC  = (CLK_HZ / 1000) * DEB_MS;
    localparam int PW = $clog2(STEP_CYC + 1);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int SW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;

    localparam logic [PW-1:0] STEP_V   = PW'(STEP_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
    localparam logic [SW-1:0] LAST     = SW'(N_LEDS - 1);
    localparam logic [N_LEDS-1:0] POL  = {N_LEDS{LED_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        ROT_L  = 2'd1,
        ROT_R  = 2'd2,
        FILL   = 2'd3
    } mode_t;

    // Index 0 is the mode button, index 1 the speed button.
    logic [1:0]         raw;
    logic [1:0]         meta;
    logic [1:0]         sync;
    logic [1:0]         deb;
    logic [1:0]         press;
    logic [1:0][DW-1:0] deb_cnt;

    assign raw = {btn_speed, btn_mode};

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            meta    <= '1;
            sync    <= '1;
            deb     <= '1;
            press   <= '0;
            deb_cnt <= '0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            press <= '0;
            for (int i = 0; i < 2; i++) begin
                if (sync[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= sync[i];
                        deb_cnt[i] <= '0;
                        press[i]   <= deb[i];
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    mode_t             mode_q, mode_n;
    logic [1:0]        speed_q, speed_n;
    logic [SW-1:0]     pos_q, pos_n;
    logic              dir_q, dir_n;
    logic [PW-1:0]     cnt_q, cnt_n;
    logic [PW-1:0]     period;
    logic              tc;
    logic              adv;
    logic [N_LEDS-1:0] pat;

    always_comb begin
        period  = STEP_V >> speed_q;
        // A zero period (over-fast speed) degrades to stepping every cycle.
        tc      = (period <= PW'(1)) || (cnt_q == period - 1'b1);
        adv     = tc && !(|press);
        mode_n  = mode_q;
        speed_n = speed_q;
        pos_n   = pos_q;
        dir_n   = dir_q;
        cnt_n   = tc ? '0 : cnt_q + 1'b1;
        if (|press) cnt_n = '0;
        if (press[1]) speed_n = speed_q + 1'b1;
        if (press[0]) begin
            mode_n = mode_t'(mode_q + 2'd1);
            pos_n  = '0;
            dir_n  = 1'b0;
        end else if (adv) begin
            unique case (mode_q)
                BOUNCE: begin
                    if (!dir_q) begin
                        if (pos_q == LAST) begin
                            dir_n = 1'b1;
                            pos_n = LAST - 1'b1;
                        end else begin
                            pos_n = pos_q + 1'b1;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_n = 1'b0;
                            pos_n = SW'(1);
                        end else begin
                            pos_n = pos_q - 1'b1;
                        end
                    end
                end
                ROT_L, FILL: pos_n = (pos_q == LAST) ? '0 : pos_q + 1'b1;
                ROT_R:       pos_n = (pos_q == '0) ? LAST : pos_q - 1'b1;
                default:     pos_n = pos_q;
            endcase
        end
        for (int i = 0; i < N_LEDS; i++) begin
            pat[i] = (mode_n == FILL) ? (SW'(i) <= pos_n) : (SW'(i) == pos_n);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            mode_q  <= BOUNCE;
            speed_q <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            step    <= 1'b0;
            led     <= {{(N_LEDS-1){1'b0}}, 1'b1} ^ POL;
        end else begin
            mode_q  <= mode_n;
            speed_q <= speed_n;
            pos_q   <= pos_n;
            dir_q   <= dir_n;
            cnt_q   <= cnt_n;
            step    <= adv;
            led     <= pat ^ POL;
        end
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl: patterns, buttons, speeds, reset.
module tb_led_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b1;
    logic       btn_speed = 1'b1;
    logic       btn_mode8 = 1'b1;
    logic       btn_speed8 = 1'b1;
    logic [5:0] led, led8;
    logic [1:0] mode, mode8;
    logic       step, step8;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .N_LEDS(6), .CLK_HZ(1000), .STEP_MS(4), .DEB_MS(2),
        .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk), .sys_rst(rst), .btn_mode(btn_mode),
        .btn_speed(btn_speed), .led(led), .mode(mode), .step(step)
    );

    led_scan_ctrl #(
        .N_LEDS(6), .CLK_HZ(1000), .STEP_MS(8), .DEB_MS(2),
        .LED_ACTIVE_LOW(1'b1)
    ) dut8 (
        .sys_clk(clk), .sys_rst(rst), .btn_mode(btn_mode8),
        .btn_speed(btn_speed8), .led(led8), .mode(mode8), .step(step8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a mode press; returns on the sample where it takes effect.
    task automatic push_mode();
        btn_mode = 1'b0;
        repeat (5) tick();
    endtask

    function automatic logic [5:0] exp_led(input int m, input int p);
        logic [5:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) v[i] = (m == 3) ? (i <= p) : (i == p);
        return ~v;
    endfunction

    task automatic model_step(input int m, inout int p, inout int d);
        case (m)
            0: begin
                if (d == 0) begin
                    if (p == 5) begin d = 1; p = 4; end
                    else p = p + 1;
                end else begin
                    if (p == 0) begin d = 0; p = 1; end
                    else p = p - 1;
                end
            end
            1, 3: p = (p + 1) % 6;
            default: p = (p == 0) ? 5 : p - 1;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (led !== 6'b111110) begin
            failures++; $display("FAIL reset_led got=%b exp=111110", led);
        end
        checks++;
        if (mode !== 2'd0) begin
            failures++; $display("FAIL reset_mode got=%0d exp=0", mode);
        end
        checks++;
        if (step !== 1'b0) begin
            failures++; $display("FAIL reset_step got=%b exp=0", step);
        end
        checks++;
        if (led8 !== 6'b111110 || step8 !== 1'b0) begin
            failures++; $display("FAIL reset_dut8 got=%b/%b exp=111110/0", led8, step8);
        end
    endtask

    task automatic test_bounce();
        int p = 0;
        int d = 0;
        logic es;
        rst = 1'b0;
        for (int k = 1; k <= 48; k++) begin
            tick();
            es = (k % 4 == 0);
            if (es) model_step(0, p, d);
            checks++;
            if (step !== es) begin
                failures++; $display("FAIL bounce_step k=%0d got=%b exp=%b", k, step, es);
            end
            checks++;
            if (led !== exp_led(0, p)) begin
                failures++; $display("FAIL bounce_led k=%0d got=%b exp=%b", k, led, exp_led(0, p));
            end
        end
    endtask

    task automatic test_speed();
        int exp_p[4] = '{4, 2, 1, 8};
        int n;
        for (n = 0; n < 20 && step8 !== 1'b1; n++) tick();
        checks++;
        if (step8 !== 1'b1) begin
            failures++; $display("FAIL speed_sync got=%b exp=1", step8);
        end
        for (n = 1; n <= 20; n++) begin tick(); if (step8 === 1'b1) break; end
        checks++;
        if (n != 8) begin
            failures++; $display("FAIL speed_base got=%0d exp=8", n);
        end
        for (int i = 0; i < 4; i++) begin
            btn_speed8 = 1'b0;
            repeat (5) tick();
            checks++;
            if (step8 !== 1'b0) begin
                failures++; $display("FAIL speed_press_step i=%0d got=%b exp=0", i, step8);
            end
            btn_speed8 = 1'b1;
            for (int j = 0; j < 2; j++) begin
                for (n = 1; n <= 20; n++) begin tick(); if (step8 === 1'b1) break; end
                checks++;
                if (n != exp_p[i]) begin
                    failures++; $display("FAIL speed_spacing i=%0d j=%0d got=%0d exp=%0d", i, j, n, exp_p[i]);
                end
            end
            checks++;
            if (mode8 !== 2'd0) begin
                failures++; $display("FAIL speed_mode i=%0d got=%0d exp=0", i, mode8);
            end
            repeat (6) tick();
        end
    endtask

    task automatic test_rotl();
        int p = 0;
        int d = 0;
        logic es;
        push_mode();
        checks++;
        if (mode !== 2'd1 || led !== 6'b111110 || step !== 1'b0) begin
            failures++; $display("FAIL rotl_enter got=%0d/%b/%b exp=1/111110/0", mode, led, step);
        end
        for (int k = 1; k <= 28; k++) begin
            if (k == 6) btn_mode = 1'b1;
            tick();
            es = (k % 4 == 0);
            if (es) model_step(1, p, d);
            checks++;
            if (step !== es || mode !== 2'd1) begin
                failures++; $display("FAIL rotl_step k=%0d got=%b/%0d exp=%b/1", k, step, mode, es);
            end
            checks++;
            if (led !== exp_led(1, p)) begin
                failures++; $display("FAIL rotl_led k=%0d got=%b exp=%b", k, led, exp_led(1, p));
            end
        end
    endtask

    task automatic test_fill();
        int p = 0;
        int d = 0;
        logic es;
        push_mode();
        checks++;
        if (mode !== 2'd2) begin
            failures++; $display("FAIL fill_mode2 got=%0d exp=2", mode);
        end
        btn_mode = 1'b1;
        repeat (6) tick();
        push_mode();
        checks++;
        if (mode !== 2'd3 || led !== 6'b111110) begin
            failures++; $display("FAIL fill_enter got=%0d/%b exp=3/111110", mode, led);
        end
        for (int k = 1; k <= 28; k++) begin
            if (k == 1) btn_mode = 1'b1;
            tick();
            es = (k % 4 == 0);
            if (es) model_step(3, p, d);
            checks++;
            if (led !== exp_led(3, p) || step !== es) begin
                failures++; $display("FAIL fill_led k=%0d got=%b/%b exp=%b/%b", k, led, step, exp_led(3, p), es);
            end
        end
        push_mode();
        checks++;
        if (mode !== 2'd0 || led !== 6'b111110) begin
            failures++; $display("FAIL fill_wrap_mode got=%0d/%b exp=0/111110", mode, led);
        end
        btn_mode = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_glitch();
        for (int g = 0; g < 3; g++) begin
            btn_mode = 1'b0;
            tick();
            btn_mode = 1'b1;
            for (int k = 0; k < 8; k++) begin
                tick();
                checks++;
                if (mode !== 2'd0) begin
                    failures++; $display("FAIL glitch_mode g=%0d got=%0d exp=0", g, mode);
                end
            end
        end
    endtask

    task automatic test_press_on_tc();
        int n;
        for (n = 0; n < 8 && step !== 1'b1; n++) tick();
        checks++;
        if (step !== 1'b1) begin
            failures++; $display("FAIL tc_sync got=%b exp=1", step);
        end
        repeat (3) tick();
        push_mode();
        checks++;
        if (mode !== 2'd1 || step !== 1'b0 || led !== 6'b111110) begin
            failures++; $display("FAIL tc_press got=%0d/%b/%b exp=1/0/111110", mode, step, led);
        end
        btn_mode = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (step !== (k == 4)) begin
                failures++; $display("FAIL tc_next k=%0d got=%b exp=%b", k, step, (k == 4));
            end
        end
        checks++;
        if (led !== 6'b111101) begin
            failures++; $display("FAIL tc_led got=%b exp=111101", led);
        end
    endtask

    task automatic test_async_reset();
        int p = 0;
        int d = 0;
        logic es;
        push_mode();
        checks++;
        if (mode !== 2'd2 || led !== 6'b111110) begin
            failures++; $display("FAIL rotr_enter got=%0d/%b exp=2/111110", mode, led);
        end
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) btn_mode = 1'b1;
            tick();
            es = (k % 4 == 0);
            if (es) model_step(2, p, d);
            checks++;
            if (led !== exp_led(2, p) || step !== es) begin
                failures++; $display("FAIL rotr_led k=%0d got=%b/%b exp=%b/%b", k, led, step, exp_led(2, p), es);
            end
        end
        repeat (2) begin
            btn_speed = 1'b0;
            repeat (5) tick();
            btn_speed = 1'b1;
            repeat (6) tick();
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (step !== 1'b1 || mode !== 2'd2) begin
                failures++; $display("FAIL fast_step k=%0d got=%b/%0d exp=1/2", k, step, mode);
            end
        end
        #4 rst = 1'b1;
        #1;
        checks++;
        if (led !== 6'b111110 || mode !== 2'd0 || step !== 1'b0) begin
            failures++; $display("FAIL async_rst got=%b/%0d/%b exp=111110/0/0", led, mode, step);
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (step !== (k == 4)) begin
                failures++; $display("FAIL rst_first_step k=%0d got=%b exp=%b", k, step, (k == 4));
            end
        end
        checks++;
        if (led !== 6'b111101) begin
            failures++; $display("FAIL rst_led got=%b exp=111101", led);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_bounce();
        test_speed();
        test_rotl();
        test_fill();
        test_glitch();
        test_press_on_tc();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
